reg_wb_mfifo: RTL

Multi-port register write-back buffer that sits between the execution units and the register file write port. It accepts up to NUM_PUSH write-back results per cycle in program order and drains one result per cycle through a valid/ready handshake. It also provides a youngest-match forwarding lookup so the issue stage can read pending results, and a synchronous flush.

---
 rtl/reg_wb_mfifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reg_wb_mfifo.sv
// Register write-back buffer: multi-port in-order push, single-port valid/ready drain,
// youngest-match forwarding lookup over stored entries, synchronous flush.
module reg_wb_mfifo #(
  parameter int DEPTH    = 4,
  parameter int NUM_PUSH = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ID_W     = 3,
  parameter int DROP_X0  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [NUM_PUSH-1:0]        push_valid_i,
  input  logic [NUM_PUSH*DATA_W-1:0] push_wdata_i,
  input  logic [NUM_PUSH*ADDR_W-1:0] push_waddr_i,
  input  logic [NUM_PUSH*ID_W-1:0]   push_id_i,
  output logic                       push_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_wdata_o,
  output logic [ADDR_W-1:0]          out_waddr_o,
  output logic [ID_W-1:0]            out_id_o,
  input  logic [ADDR_W-1:0]          lkp_addr_i,
  output logic                       lkp_hit_o,
  output logic [DATA_W-1:0]          lkp_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Handshake: a head entry transfers on a cycle where out_valid_o && out_ready_i at the
  // rising edge; push ports transfer where push_valid_i[i] && push_ready_o at the edge.

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ID_W-1:0]   id_q   [DEPTH];

  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [NUM_PUSH-1:0] store_en;
  ptr_t                store_idx [NUM_PUSH];
  logic [CNT_W-1:0]    n_stored;
  logic                pop;
  ptr_t                lkp_idx;

  // Ready only looks at registered occupancy so it never depends on out_ready_i.
  assign push_ready_o = (count_q <= CNT_W'(DEPTH - NUM_PUSH));
  assign out_valid_o  = (count_q != '0);
  assign pop          = out_valid_o && out_ready_i && !flush_i;
  assign count_o      = count_q;

  // Compact accepted ports in port order; dropped x0 writes consume no slot.
  always_comb begin
    n_stored = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      store_en[i]  = push_valid_i[i] && push_ready_o && !flush_i &&
                     !((DROP_X0 != 0) && (push_waddr_i[i*ADDR_W +: ADDR_W] == '0));
      store_idx[i] = wr_ptr_q + n_stored[PTR_W-1:0];
      if (store_en[i]) n_stored = n_stored + CNT_W'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + n_stored[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    count_d  = count_q + n_stored - CNT_W'(pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload carries no reset; validity is defined by pointers and count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (store_en[i]) begin
        data_q[store_idx[i]] <= push_wdata_i[i*DATA_W +: DATA_W];
        addr_q[store_idx[i]] <= push_waddr_i[i*ADDR_W +: ADDR_W];
        id_q[store_idx[i]]   <= push_id_i[i*ID_W +: ID_W];
      end
    end
  end

  assign out_wdata_o = out_valid_o ? data_q[rd_ptr_q] : '0;
  assign out_waddr_o = out_valid_o ? addr_q[rd_ptr_q] : '0;
  assign out_id_o    = out_valid_o ? id_q[rd_ptr_q]   : '0;

  // Walk oldest to youngest so the last match (nearest wr_ptr) wins.
  always_comb begin
    lkp_hit_o  = 1'b0;
    lkp_data_o = '0;
    lkp_idx    = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      lkp_idx = rd_ptr_q + ptr_t'(k);
      if ((CNT_W'(k) < count_q) && (lkp_addr_i != '0) && (addr_q[lkp_idx] == lkp_addr_i)) begin
        lkp_hit_o  = 1'b1;
        lkp_data_o = data_q[lkp_idx];
      end
    end
  end

endmodule
